btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//  Front end of the keypad path: takes the 9 raw, asynchronous, bouncing push-button inputs and
//  produces clean one-cycle press pulses for the code-entry stage, whose btns[8:0] input it drives.
//  Per button it provides 2-FF synchronisation and counter debounce. A single arbiter emits at most
//  one pulse per cycle, so one physical press yields exactly one digit.
// PARAMETERS
//  N_BTNS           9       number of buttons, bit i = button i
//  DEBOUNCE_CYCLES  500000  cycles a synchronised level must hold before acceptance (10 ms @ 50 MHz); must be >= 2
//  CNT_W            $clog2(DEBOUNCE_CYCLES)  debounce counter width (derived, do not override)
// PORTS
//  clk        in   1       system clock, single clock domain
//  rst        in   1       synchronous, active-high reset
//  btns_raw   in   N_BTNS  raw button levels, asynchronous, 1 = pressed
//  btn_pulse  out  N_BTNS  one-cycle press pulse, at most one bit set per cycle; feeds code-entry btns
//  btn_held   out  N_BTNS  debounced stable level per button
//  any_pulse  out  1       |btn_pulse, asserted in the same cycle as btn_pulse
// BEHAVIOUR
//  - Reset (sync, rst=1 at a clk edge): sync FFs, counters, stable levels, btn_pulse, btn_held and
//    any_pulse all go to 0. Reset mid-debounce discards any partial count.
//  - Sync: s1 <= btns_raw and s2 <= s1 per bit. Only s2 is used downstream.
//  - Debounce, per bit:
//    - if s2 == stable: cnt <= 0.
//    - if s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0.
//    - otherwise: cnt <= cnt+1.
//    - Any bounce back to the stable value restarts the count from 0. No saturation or wrap is
//      possible because cnt never exceeds DEBOUNCE_CYCLES-1.
//  - btn_held = stable (registered).
//  - Edge detect: rise[i] = stable[i] & ~stable_d[i], where stable_d is stable delayed one cycle.
//    Release edges produce no output.
//  - Arbitration, registered into btn_pulse:
//    - candidate set: rise[i] with no other button j != i having stable_d[j] == 1.
//      A press while another button is already held is ignored, not deferred.
//    - several candidates in the same cycle: only the lowest index pulses; the others are dropped.
//  - Latency: btns_raw goes high before edge E and stays clean. stable rises after edge E+DEBOUNCE_CYCLES+1.
//    btn_pulse[i] is high for exactly the one cycle after edge E+DEBOUNCE_CYCLES+2.
//    Release follows the same timing for btn_held.
//  - A held button gives exactly one pulse, with no auto-repeat. A second pulse needs a debounced
//    release then a debounced press.
//  - A button held through reset release counts as a new press: it pulses after the normal latency.
//  - Inputs 6..8 are conditioned like any other button, even though code entry uses only 0..5.
// STRUCTURE
//  - Package lock_pkg holds:
//    - constants N_BTNS=9 and DEBOUNCE_CYCLES_DEFAULT=500000;
//    - typedef btn_vec_t = logic [N_BTNS-1:0], shared with the code-entry stage.
//  - One sub-module, btn_debounce: a single channel of sync FFs, counter and stable register,
//    with ports clk, rst, raw, stable. It is instantiated N_BTNS times in a generate loop.
//  - The top level holds stable_d, the edge detect, the arbiter and the output registers.
// TESTING  (bench uses DEBOUNCE_CYCLES=4)
//  1. Clean press: btns_raw[2]=1 from edge 10, held 20 cycles
//     -> btn_held[2]=1 after edge 15; btn_pulse=9'h004 for one cycle after edge 16; no further pulses.
//  2. Bounce: btns_raw[0] toggles 1,0,1,0 over edges 10..13, then stays 1
//     -> no pulse during the toggling; btn_pulse=9'h001 exactly once, 7 edges after the last 0->1.
//  3. Simultaneous: btns_raw=9'h028 (buttons 3 and 5) at the same edge
//     -> btn_pulse=9'h008 once; bit 5 never pulses; btn_held=9'h028.
//  4. Held-other: press button 1, then press button 4 while 1 is still held
//     -> only 9'h002 pulses; button 4 gives no pulse; release both, re-press 4 -> 9'h010 once.
//  5. Reset mid-operation: rst=1 for one edge while cnt for button 6 is 2
//     -> all outputs 0 next cycle; with raw still 1, pulse 9'h040 arrives a full latency (7 edges) after rst drops.
//  6. Repeat: press/release button 5 three times, each phase 10 cycles
//     -> exactly three 9'h020 pulses; any_pulse matches |btn_pulse every cycle.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared keypad-path definitions: button count, default debounce length and the
// button vector type also used by the code-entry stage.
package lock_pkg;

   localparam int unsigned N_BTNS                  = 9;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

   typedef logic [N_BTNS-1:0] btn_vec_t;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser followed by a counter debounce that only
// accepts a new level after it has held for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable
);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
         // Any return to the accepted level restarts the count.
         if (s2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/btn_conditioner.sv
// Keypad front end: per-button sync/debounce, press-edge detect and a single-winner
// arbiter so each physical press yields exactly one registered one-cycle pulse.
module btn_conditioner
   import lock_pkg::*;
#(
   parameter int unsigned N_BTNS          = lock_pkg::N_BTNS,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_BTNS-1:0] btns_raw,
   output logic [N_BTNS-1:0] btn_pulse,
   output logic [N_BTNS-1:0] btn_held,
   output logic              any_pulse
);

   logic [N_BTNS-1:0] stable;
   logic [N_BTNS-1:0] stable_d;
   logic [N_BTNS-1:0] rise;
   logic [N_BTNS-1:0] others;
   logic [N_BTNS-1:0] next_pulse;

   for (genvar g = 0; g < N_BTNS; g++) begin : g_chan
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clk    (clk),
         .rst    (rst),
         .raw    (btns_raw[g]),
         .stable (stable[g])
      );
   end

   assign btn_held = stable;

   // A press is only a candidate when no other button is already held;
   // among simultaneous candidates the lowest index wins, the rest are dropped.
   always_comb begin
      rise       = stable & ~stable_d;
      others     = '0;
      next_pulse = '0;
      for (int unsigned i = 0; i < N_BTNS; i++) begin
         others    = stable_d;
         others[i] = 1'b0;
         if (rise[i] && (others == '0) && (next_pulse == '0)) begin
            next_pulse[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stable_d  <= '0;
         btn_pulse <= '0;
         any_pulse <= 1'b0;
      end else begin
         stable_d  <= stable;
         btn_pulse <= next_pulse;
         any_pulse <= |next_pulse;
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed and random bench for btn_conditioner with a short debounce, compared
// every cycle against a history-based reference model.
module tb_btn_conditioner;

   localparam int unsigned D = 4;

   logic       clk;
   logic       rst;
   logic [8:0] btns_raw;
   logic [8:0] btn_pulse;
   logic [8:0] btn_held;
   logic       any_pulse;

   int n_checks = 0;
   int n_fails  = 0;
   int pcnt[9];

   // Reference model state
   logic [8:0] rawq[$];
   logic [8:0] s2q[$];
   logic [8:0] m_stable   = '0;
   logic [8:0] m_stable_d = '0;
   logic [8:0] m_pulse    = '0;

   btn_conditioner #(
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btns_raw  (btns_raw),
      .btn_pulse (btn_pulse),
      .btn_held  (btn_held),
      .any_pulse (any_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: observed no finish, expected finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // A level is accepted once the synchronised input (raw delayed two edges) has
   // differed from the accepted level on each of the last D edges. A press pulses
   // only if nothing was held the cycle before; the lowest-index press wins.
   task automatic model_edge(input logic [8:0] raw_in, input logic rst_in);
      logic [8:0] s2_now, flip, rise, cand;
      if (rst_in) begin
         rawq.delete();
         s2q.delete();
         m_stable   = '0;
         m_stable_d = '0;
         m_pulse    = '0;
         return;
      end
      s2_now = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 9'h000;
      rawq.push_back(raw_in);
      if (rawq.size() > 4) void'(rawq.pop_front());
      s2q.push_back(s2_now);
      if (s2q.size() > D) void'(s2q.pop_front());
      flip = '0;
      if (s2q.size() == D) begin
         flip = '1;
         foreach (s2q[k]) flip &= s2q[k] ^ m_stable;
      end
      rise       = m_stable & ~m_stable_d;
      cand       = (m_stable_d == 9'h000) ? rise : 9'h000;
      m_pulse    = cand & (~cand + 9'd1);
      m_stable_d = m_stable;
      m_stable   = m_stable ^ flip;
   endtask

   task automatic step(input logic [8:0] r, input logic rs);
      btns_raw = r;
      rst      = rs;
      @(posedge clk);
      model_edge(r, rs);
      #2;
      chk("held", btn_held, m_stable);
      chk("pulse", btn_pulse, m_pulse);
      chk("any", {8'h00, any_pulse}, {8'h00, |m_pulse});
      chk("any_vs_pulse", {8'h00, any_pulse}, {8'h00, |btn_pulse});
      for (int i = 0; i < 9; i++) if (btn_pulse[i]) pcnt[i]++;
      @(negedge clk);
   endtask

   task automatic clear_counts();
      foreach (pcnt[i]) pcnt[i] = 0;
   endtask

   task automatic hold(input logic [8:0] r, input int n);
      for (int i = 0; i < n; i++) step(r, 1'b0);
   endtask

   initial begin
      logic [8:0] seg;
      btns_raw = '0;
      rst      = 1'b1;
      clear_counts();
      @(negedge clk);

      // Reset state
      step(9'h000, 1'b1);
      step(9'h1FF, 1'b1);
      chk("rst_held", btn_held, 9'h000);
      chk("rst_pulse", btn_pulse, 9'h000);
      chk("rst_any", {8'h00, any_pulse}, 9'h000);
      hold(9'h000, 4);

      // 1. Clean press on button 2
      clear_counts();
      for (int j = 0; j < 20; j++) begin
         step(9'h004, 1'b0);
         if (j == 4) chk("t1_held_early", btn_held, 9'h000);
         if (j == 5) chk("t1_held", btn_held, 9'h004);
         if (j == 6) chk("t1_pulse", btn_pulse, 9'h004);
         if (j == 7) chk("t1_pulse_once", btn_pulse, 9'h000);
      end
      hold(9'h000, 10);
      chk_int("t1_count", pcnt[2], 1);

      // 2. Bounce on button 0
      clear_counts();
      step(9'h001, 1'b0);
      step(9'h000, 1'b0);
      step(9'h001, 1'b0);
      step(9'h000, 1'b0);
      for (int j = 0; j < 15; j++) begin
         step(9'h001, 1'b0);
         if (j == 5) chk("t2_no_pulse_yet", btn_pulse, 9'h000);
         if (j == 6) chk("t2_pulse", btn_pulse, 9'h001);
      end
      hold(9'h000, 10);
      chk_int("t2_count", pcnt[0], 1);

      // 3. Simultaneous buttons 3 and 5
      clear_counts();
      hold(9'h028, 12);
      chk("t3_held", btn_held, 9'h028);
      hold(9'h000, 10);
      chk_int("t3_count3", pcnt[3], 1);
      chk_int("t3_count5", pcnt[5], 0);

      // 4. Press while another is held is ignored
      clear_counts();
      hold(9'h002, 8);
      hold(9'h012, 10);
      chk_int("t4_count1", pcnt[1], 1);
      chk_int("t4_count4_blocked", pcnt[4], 0);
      hold(9'h000, 10);
      hold(9'h010, 10);
      hold(9'h000, 10);
      chk_int("t4_count4_repress", pcnt[4], 1);

      // 5. Reset mid-debounce of button 6
      clear_counts();
      hold(9'h040, 4);
      step(9'h040, 1'b1);
      chk("t5_rst_held", btn_held, 9'h000);
      chk("t5_rst_pulse", btn_pulse, 9'h000);
      for (int j = 0; j < 10; j++) begin
         step(9'h040, 1'b0);
         if (j == 5) chk("t5_no_pulse_yet", btn_pulse, 9'h000);
         if (j == 6) chk("t5_pulse", btn_pulse, 9'h040);
      end
      hold(9'h000, 10);
      chk_int("t5_count", pcnt[6], 1);

      // 6. Repeated presses of button 5
      clear_counts();
      for (int k = 0; k < 3; k++) begin
         hold(9'h020, 10);
         hold(9'h000, 10);
      end
      chk_int("t6_count", pcnt[5], 3);

      // Random segments: idle, single presses, multi-button and bounce patterns
      seg = '0;
      for (int s = 0; s < 80; s++) begin
         case ($urandom_range(0, 3))
            0: seg = '0;
            1: seg = 9'h001 << $urandom_range(0, 8);
            2: seg = 9'($urandom);
            default: seg = seg ^ (9'h001 << $urandom_range(0, 8));
         endcase
         if ($urandom_range(0, 19) == 0) step(seg, 1'b1);
         hold(seg, int'($urandom_range(1, 10)));
      end
      hold(9'h000, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
